// File: rtl/free_list_pkg.sv
// Shared types and sizing for the rename-stage free list and its ROB neighbours.
package free_list_pkg;

  localparam int unsigned NUM_PR   = 64;
  localparam int unsigned NUM_ARCH = 32;
  localparam int unsigned NUM_ROB  = 8;
  // Must be a power of two so the pointer low bits index the array directly.
  localparam int unsigned NUM_FL   = NUM_PR - NUM_ARCH;

  localparam int unsigned PR_W     = $clog2(NUM_PR);
  localparam int unsigned ROB_W    = $clog2(NUM_ROB);
  localparam int unsigned FL_IDX_W = $clog2(NUM_FL);
  // Extra MSB is the wrap bit that separates full from empty.
  localparam int unsigned FL_PTR_W = FL_IDX_W + 1;

  typedef logic [FL_PTR_W-1:0] fl_ptr_t;

  typedef struct packed {
    logic [PR_W-1:0] Told_idx;
    logic            Told_valid;
  } ROB_FL_OUT_t;

  typedef struct packed {
    logic [PR_W-1:0] T_idx;
  } FL_ROB_OUT_t;

  typedef struct packed {
    logic [PR_W-1:0] T_idx;
  } FL_MAP_TABLE_OUT_t;

  // Occupancy from wrap-bit pointers; modular subtraction handles wrap.
  function automatic fl_ptr_t fl_count(input fl_ptr_t tail, input fl_ptr_t head);
    return tail - head;
  endfunction

endpackage

// File: rtl/free_list_if.sv
// Dispatch / retire / rollback bundle between the ROB+rename side and the free list.
interface free_list_if;
  import free_list_pkg::*;

  logic                 en;
  logic                 dispatch_en;
  logic                 dest_valid;
  logic [ROB_W-1:0]     ROB_idx;
  logic                 retire_en;
  ROB_FL_OUT_t          ROB_FL_out;
  logic                 rollback_en;
  logic [ROB_W-1:0]     ROB_rollback_idx;
  logic                 FL_valid;
  FL_ROB_OUT_t          FL_ROB_out;
  FL_MAP_TABLE_OUT_t    FL_Map_Table_out;

  // Rename/ROB side.
  modport master (
    output en, dispatch_en, dest_valid, ROB_idx, retire_en, ROB_FL_out,
           rollback_en, ROB_rollback_idx,
    input  FL_valid, FL_ROB_out, FL_Map_Table_out
  );

  // Free list side.
  modport slave (
    input  en, dispatch_en, dest_valid, ROB_idx, retire_en, ROB_FL_out,
           rollback_en, ROB_rollback_idx,
    output FL_valid, FL_ROB_out, FL_Map_Table_out
  );

endinterface

// File: rtl/free_list.sv
// Circular FIFO of free physical register tags with per-ROB-entry head checkpoints
// for branch rollback.
module free_list
  import free_list_pkg::*;
(
  input logic        clock,
  input logic        reset,
  free_list_if.slave fl_if
);

  logic [PR_W-1:0] fl_q    [NUM_FL];
  logic [PR_W-1:0] fl_d    [NUM_FL];
  fl_ptr_t         ckpt_q  [NUM_ROB];
  fl_ptr_t         ckpt_d  [NUM_ROB];
  fl_ptr_t         head_q, head_d;
  fl_ptr_t         tail_q, tail_d;

  fl_ptr_t count;
  logic    fl_valid;
  logic    full;
  logic    rollback;
  logic    pop;
  logic    push_req;
  logic    push;
  logic    ckpt_we;

  assign count    = fl_count(tail_q, head_q);
  assign fl_valid = (count != '0);
  assign full     = (count == fl_ptr_t'(NUM_FL));

  assign rollback = fl_if.en & fl_if.rollback_en;
  // Gated by FL_valid, so a pop never underflows; no bypass from a same-cycle push.
  assign pop      = fl_if.en & fl_if.dispatch_en & fl_if.dest_valid & fl_valid
                    & ~fl_if.rollback_en;
  assign push_req = fl_if.en & fl_if.retire_en & fl_if.ROB_FL_out.Told_valid;
  // A push into a full list is a protocol error and is dropped.
  assign push     = push_req & ~full;
  // Checkpoint every dispatch, even without a destination, so any ROB slot can roll back.
  assign ckpt_we  = fl_if.en & fl_if.dispatch_en & ~fl_if.rollback_en;

  // Head tag is presented combinationally to both the ROB and the Map Table.
  always_comb begin
    fl_if.FL_valid               = fl_valid;
    fl_if.FL_ROB_out.T_idx       = fl_q[head_q[FL_IDX_W-1:0]];
    fl_if.FL_Map_Table_out.T_idx = fl_q[head_q[FL_IDX_W-1:0]];
  end

  // Next-state for pointers, tag storage and checkpoints.
  always_comb begin
    head_d = head_q;
    tail_d = tail_q;
    fl_d   = fl_q;
    ckpt_d = ckpt_q;

    if (rollback) begin
      head_d = ckpt_q[fl_if.ROB_rollback_idx];
    end else if (pop) begin
      head_d = head_q + fl_ptr_t'(1);
    end

    // Retire is older than any mispredicted branch, so it proceeds during rollback.
    if (push) begin
      fl_d[tail_q[FL_IDX_W-1:0]] = fl_if.ROB_FL_out.Told_idx;
      tail_d                     = tail_q + fl_ptr_t'(1);
    end

    // Checkpoint holds the head after this cycle's pop.
    if (ckpt_we) begin
      ckpt_d[fl_if.ROB_idx] = head_d;
    end
  end

  // State registers; reset leaves PRs NUM_ARCH.. free and the list full.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      head_q <= '0;
      tail_q <= fl_ptr_t'(NUM_FL);
      for (int i = 0; i < NUM_FL; i++) begin
        fl_q[i] <= PR_W'(NUM_ARCH + i);
      end
      for (int i = 0; i < NUM_ROB; i++) begin
        ckpt_q[i] <= '0;
      end
    end else begin
      head_q <= head_d;
      tail_q <= tail_d;
      fl_q   <= fl_d;
      ckpt_q <= ckpt_d;
    end
  end

  push_not_full_a: assert property (@(posedge clock) disable iff (reset) !(push_req && full));

endmodule

// File: tb/tb_free_list.sv
// Directed self-checking bench for the free list.
module tb_free_list;
  import free_list_pkg::*;

  logic clock = 1'b0;
  logic reset = 1'b1;
  int   pass_cnt = 0;
  int   total_cnt = 0;

  free_list_if fl_if ();

  free_list dut (
    .clock (clock),
    .reset (reset),
    .fl_if (fl_if)
  );

  always #5 clock = ~clock;

  task automatic idle();
    fl_if.en                    = 1'b1;
    fl_if.dispatch_en           = 1'b0;
    fl_if.dest_valid            = 1'b0;
    fl_if.ROB_idx               = '0;
    fl_if.retire_en             = 1'b0;
    fl_if.ROB_FL_out.Told_idx   = '0;
    fl_if.ROB_FL_out.Told_valid = 1'b0;
    fl_if.rollback_en           = 1'b0;
    fl_if.ROB_rollback_idx      = '0;
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic apply_reset();
    idle();
    reset = 1'b1;
    step();
    reset = 1'b0;
  endtask

  task automatic dispatch(input logic [ROB_W-1:0] rob, input logic dv);
    fl_if.dispatch_en = 1'b1;
    fl_if.dest_valid  = dv;
    fl_if.ROB_idx     = rob;
    step();
    fl_if.dispatch_en = 1'b0;
    fl_if.dest_valid  = 1'b0;
  endtask

  task automatic test_reset();
    idle();
    // Reset asserted mid-dispatch and mid-rollback must win.
    fl_if.dispatch_en = 1'b1;
    fl_if.dest_valid  = 1'b1;
    fl_if.rollback_en = 1'b1;
    @(negedge clock);
    reset = 1'b1;
    #2;
    total_cnt++;
    if (fl_if.FL_valid !== 1'b1) $display("FAIL reset_valid: got %b want 1", fl_if.FL_valid);
    else pass_cnt++;
    total_cnt++;
    if (fl_if.FL_ROB_out.T_idx !== 6'd32)
      $display("FAIL reset_t_idx: got %0d want 32", fl_if.FL_ROB_out.T_idx);
    else pass_cnt++;
    total_cnt++;
    if (fl_if.FL_Map_Table_out.T_idx !== 6'd32)
      $display("FAIL reset_map_t_idx: got %0d want 32", fl_if.FL_Map_Table_out.T_idx);
    else pass_cnt++;
    step();
    reset = 1'b0;
    fl_if.rollback_en = 1'b0;
    for (int i = 0; i < 32; i++) begin
      fl_if.ROB_idx = 3'(i);
      total_cnt++;
      if (fl_if.FL_valid !== 1'b1 || fl_if.FL_ROB_out.T_idx !== 6'(32 + i))
        $display("FAIL reset_pop_seq[%0d]: got valid=%b tag=%0d want valid=1 tag=%0d",
                 i, fl_if.FL_valid, fl_if.FL_ROB_out.T_idx, 32 + i);
      else pass_cnt++;
      step();
    end
    fl_if.dispatch_en = 1'b0;
    fl_if.dest_valid  = 1'b0;
    total_cnt++;
    if (fl_if.FL_valid !== 1'b0) $display("FAIL reset_drained_valid: got %b want 0", fl_if.FL_valid);
    else pass_cnt++;
  endtask

  task automatic test_enable();
    apply_reset();
    fl_if.en                    = 1'b0;
    fl_if.dispatch_en           = 1'b1;
    fl_if.dest_valid            = 1'b1;
    fl_if.retire_en             = 1'b1;
    fl_if.ROB_FL_out.Told_idx   = 6'd3;
    fl_if.ROB_FL_out.Told_valid = 1'b1;
    step();
    idle();
    total_cnt++;
    if (fl_if.FL_ROB_out.T_idx !== 6'd32)
      $display("FAIL enable_low_hold: got %0d want 32", fl_if.FL_ROB_out.T_idx);
    else pass_cnt++;
    dispatch(3'd0, 1'b1);
    total_cnt++;
    if (fl_if.FL_ROB_out.T_idx !== 6'd33)
      $display("FAIL enable_high_pop: got %0d want 33", fl_if.FL_ROB_out.T_idx);
    else pass_cnt++;
  endtask

  task automatic test_empty_push();
    apply_reset();
    for (int i = 0; i < 32; i++) dispatch(3'(i), 1'b1);
    fl_if.retire_en             = 1'b1;
    fl_if.ROB_FL_out.Told_idx   = 6'd5;
    fl_if.ROB_FL_out.Told_valid = 1'b1;
    fl_if.dispatch_en           = 1'b1;
    fl_if.dest_valid            = 1'b1;
    total_cnt++;
    if (fl_if.FL_valid !== 1'b0) $display("FAIL empty_no_bypass: got %b want 0", fl_if.FL_valid);
    else pass_cnt++;
    step();
    idle();
    total_cnt++;
    if (fl_if.FL_valid !== 1'b1 || fl_if.FL_ROB_out.T_idx !== 6'd5)
      $display("FAIL empty_push_tag: got valid=%b tag=%0d want valid=1 tag=5",
               fl_if.FL_valid, fl_if.FL_ROB_out.T_idx);
    else pass_cnt++;
    dispatch(3'd0, 1'b1);
    total_cnt++;
    if (fl_if.FL_valid !== 1'b0) $display("FAIL empty_push_single: got %b want 0", fl_if.FL_valid);
    else pass_cnt++;
  endtask

  task automatic test_push_pop();
    int n;
    apply_reset();
    for (int i = 0; i < 4; i++) dispatch(3'(i), 1'b1);
    fl_if.retire_en             = 1'b1;
    fl_if.ROB_FL_out.Told_idx   = 6'd9;
    fl_if.ROB_FL_out.Told_valid = 1'b1;
    total_cnt++;
    if (fl_if.FL_ROB_out.T_idx !== 6'd36)
      $display("FAIL pushpop_head: got %0d want 36", fl_if.FL_ROB_out.T_idx);
    else pass_cnt++;
    dispatch(3'd4, 1'b1);
    idle();
    // 28 free before and after; 37..63 then 9 in FIFO order.
    n = 0;
    for (int i = 0; i < 40; i++) begin
      if (fl_if.FL_valid !== 1'b1) break;
      total_cnt++;
      if (fl_if.FL_ROB_out.T_idx !== ((n < 27) ? 6'(37 + n) : 6'd9))
        $display("FAIL pushpop_drain[%0d]: got %0d want %0d", n, fl_if.FL_ROB_out.T_idx,
                 (n < 27) ? 37 + n : 9);
      else pass_cnt++;
      dispatch(3'(n), 1'b1);
      n++;
    end
    total_cnt++;
    if (n != 28) $display("FAIL pushpop_count: got %0d want 28", n);
    else pass_cnt++;
  endtask

  task automatic test_rollback();
    apply_reset();
    for (int i = 0; i < 4; i++) dispatch(3'(i), 1'b1);
    fl_if.rollback_en      = 1'b1;
    fl_if.ROB_rollback_idx = 3'd1;
    fl_if.dispatch_en      = 1'b1;
    fl_if.dest_valid       = 1'b1;
    fl_if.ROB_idx          = 3'd4;
    total_cnt++;
    if (fl_if.FL_ROB_out.T_idx !== 6'd36)
      $display("FAIL rollback_before: got %0d want 36", fl_if.FL_ROB_out.T_idx);
    else pass_cnt++;
    step();
    idle();
    total_cnt++;
    if (fl_if.FL_ROB_out.T_idx !== 6'd34)
      $display("FAIL rollback_restore: got %0d want 34", fl_if.FL_ROB_out.T_idx);
    else pass_cnt++;
    dispatch(3'd2, 1'b1);
    total_cnt++;
    if (fl_if.FL_ROB_out.T_idx !== 6'd35)
      $display("FAIL rollback_reissue: got %0d want 35", fl_if.FL_ROB_out.T_idx);
    else pass_cnt++;
  endtask

  task automatic test_ckpt_no_dest();
    apply_reset();
    dispatch(3'd0, 1'b1);
    dispatch(3'd1, 1'b0);
    dispatch(3'd2, 1'b1);
    fl_if.rollback_en      = 1'b1;
    fl_if.ROB_rollback_idx = 3'd1;
    step();
    idle();
    total_cnt++;
    if (fl_if.FL_ROB_out.T_idx !== 6'd33)
      $display("FAIL ckpt_no_dest: got %0d want 33", fl_if.FL_ROB_out.T_idx);
    else pass_cnt++;
  endtask

  task automatic test_rollback_retire();
    int n;
    apply_reset();
    for (int i = 0; i < 4; i++) dispatch(3'(i), 1'b1);
    fl_if.rollback_en           = 1'b1;
    fl_if.ROB_rollback_idx      = 3'd1;
    fl_if.retire_en             = 1'b1;
    fl_if.ROB_FL_out.Told_idx   = 6'd7;
    fl_if.ROB_FL_out.Told_valid = 1'b1;
    step();
    idle();
    total_cnt++;
    if (fl_if.FL_ROB_out.T_idx !== 6'd34)
      $display("FAIL rbretire_head: got %0d want 34", fl_if.FL_ROB_out.T_idx);
    else pass_cnt++;
    // 34..63 then tag 7 written at the wrapped slot.
    n = 0;
    for (int i = 0; i < 40; i++) begin
      if (fl_if.FL_valid !== 1'b1) break;
      if (n == 30) begin
        total_cnt++;
        if (fl_if.FL_ROB_out.T_idx !== 6'd7)
          $display("FAIL rbretire_wrap_tag: got %0d want 7", fl_if.FL_ROB_out.T_idx);
        else pass_cnt++;
      end
      dispatch(3'(n), 1'b1);
      n++;
    end
    total_cnt++;
    if (n != 31) $display("FAIL rbretire_count: got %0d want 31", n);
    else pass_cnt++;
  endtask

  task automatic test_wraparound();
    int   fq[$];
    int   inflight[$];
    bit   in_use[64];
    int   exp_tag;
    int   r;
    int   n;
    apply_reset();
    for (int i = 0; i < 64; i++) in_use[i] = 1'b0;
    for (int i = 0; i < 32; i++) fq.push_back(32 + i);
    for (int i = 0; i < 8; i++) begin
      exp_tag = fq.pop_front();
      in_use[exp_tag] = 1'b1;
      inflight.push_back(exp_tag);
      dispatch(3'(i), 1'b1);
    end
    for (int k = 0; k < 40; k++) begin
      exp_tag = fq[0];
      total_cnt++;
      if (fl_if.FL_valid !== 1'b1 || fl_if.FL_ROB_out.T_idx !== 6'(exp_tag))
        $display("FAIL wrap_pop[%0d]: got valid=%b tag=%0d want valid=1 tag=%0d",
                 k, fl_if.FL_valid, fl_if.FL_ROB_out.T_idx, exp_tag);
      else pass_cnt++;
      total_cnt++;
      if (in_use[fl_if.FL_ROB_out.T_idx] !== 1'b0)
        $display("FAIL wrap_dup[%0d]: tag %0d in use, want a free tag", k,
                 fl_if.FL_ROB_out.T_idx);
      else pass_cnt++;
      r = inflight.pop_front();
      fl_if.retire_en             = 1'b1;
      fl_if.ROB_FL_out.Told_idx   = 6'(r);
      fl_if.ROB_FL_out.Told_valid = 1'b1;
      dispatch(3'(k), 1'b1);
      idle();
      in_use[r] = 1'b0;
      fq.push_back(r);
      exp_tag = fq.pop_front();
      in_use[exp_tag] = 1'b1;
      inflight.push_back(exp_tag);
    end
    n = 0;
    for (int i = 0; i < 40; i++) begin
      if (fl_if.FL_valid !== 1'b1) break;
      if (fq.size() == 0) begin
        total_cnt++;
        $display("FAIL wrap_drain_extra: got extra tag %0d want none", fl_if.FL_ROB_out.T_idx);
        break;
      end
      exp_tag = fq.pop_front();
      total_cnt++;
      if (fl_if.FL_ROB_out.T_idx !== 6'(exp_tag))
        $display("FAIL wrap_drain[%0d]: got %0d want %0d", n, fl_if.FL_ROB_out.T_idx, exp_tag);
      else pass_cnt++;
      dispatch(3'(i), 1'b1);
      n++;
    end
    total_cnt++;
    if (n != 24) $display("FAIL wrap_count: got %0d want 24", n);
    else pass_cnt++;
  endtask

  initial begin
    idle();
    test_reset();
    test_enable();
    test_empty_push();
    test_push_pop();
    test_rollback();
    test_ckpt_no_dest();
    test_rollback_retire();
    test_wraparound();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
